// File: rtl/cdc_in_arbiter_pkg.sv
// Shared types and helpers for the usb_cdc IN-channel packet arbiter.
// Holds the FSM encoding, the byte/last beat payload and index-width helper.
package cdc_in_arbiter_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned MAX_REQUESTERS = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic              last;
    logic [BYTE_W-1:0] data;
  } arb_beat_t;

  // Index width that stays legal for a single requester.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdc_in_arbiter_picker.sv
// Combinational round-robin picker: first set req bit at or after ptr, cyclically.
// Built as a double-width masked priority encoder.
module rr_picker
  import cdc_in_arbiter_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     pick,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [N-1:0]   mask;
  logic [2*N-1:0] dbl;

  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < N; i++) begin
      mask[i] = (i >= 32'(ptr));
    end
  end

  // Low half favours indices >= ptr; the unmasked high half supplies the wrap-around.
  assign dbl = {req, req & mask};

  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int unsigned i = 0; i < 2 * N; i++) begin
      if (!any && dbl[i]) begin
        any = 1'b1;
        idx = IDX_W'(i % N);
      end
    end
  end

  assign pick = any ? (N'(1) << idx) : '0;

endmodule

// File: rtl/cdc_in_arbiter.sv
// Round-robin packet arbiter sharing one usb_cdc IN lane among byte-stream requesters.
// A grant lasts until the last byte, a burst cap, or an idle timeout.
module cdc_in_arbiter
  import cdc_in_arbiter_pkg::*;
#(
  parameter int unsigned REQUESTERS   = 4,
  parameter int unsigned MAX_BURST    = 64,
  parameter int unsigned IDLE_TIMEOUT = 16
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic [BYTE_W*REQUESTERS-1:0] req_data_i,
  input  logic [REQUESTERS-1:0]        req_valid_i,
  input  logic [REQUESTERS-1:0]        req_last_i,
  output logic [REQUESTERS-1:0]        req_ready_o,
  output logic [BYTE_W-1:0]            out_data_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [REQUESTERS-1:0]        grant_o,
  output logic                         busy_o
);

  localparam int unsigned IDX_W   = idx_width(REQUESTERS);
  localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);
  localparam int unsigned IDLE_W  = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REQUESTERS - 1);

`ifndef SYNTHESIS
  if (REQUESTERS == 0 || REQUESTERS > MAX_REQUESTERS) begin : g_bad_requesters
    $error("cdc_in_arbiter: REQUESTERS must be 1..16");
  end
  if (MAX_BURST == 0) begin : g_bad_burst
    $error("cdc_in_arbiter: MAX_BURST must be >= 1");
  end
  if (IDLE_TIMEOUT == 0) begin : g_bad_timeout
    $error("cdc_in_arbiter: IDLE_TIMEOUT must be >= 1");
  end
`endif

  arb_state_e             state_q, state_d;
  logic [REQUESTERS-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]       gidx_q, gidx_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [BURST_W-1:0]     burst_q, burst_d;
  logic [IDLE_W-1:0]      idle_q, idle_d;

  logic [REQUESTERS-1:0]  pick;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;

  arb_beat_t              beat_g;
  logic                   valid_g;
  logic                   xfer;
  logic [BURST_W-1:0]     burst_inc;
  logic [IDLE_W-1:0]      idle_inc;
  logic                   burst_hit;
  logic                   idle_hit;
  logic                   rel;
  logic [IDX_W-1:0]       ptr_adv;

  rr_picker #(
    .N     (REQUESTERS),
    .IDX_W (IDX_W)
  ) u_picker (
    .req  (req_valid_i),
    .ptr  (ptr_q),
    .pick (pick),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // Granted requester's lane, selected by the registered grant index.
  always_comb begin
    beat_g.last = req_last_i[gidx_q];
    beat_g.data = req_data_i[BYTE_W*gidx_q +: BYTE_W];
    valid_g     = req_valid_i[gidx_q];
  end

  // Zero-latency data path while granted; quiet in IDLE.
  always_comb begin
    out_valid_o = 1'b0;
    out_data_o  = '0;
    req_ready_o = '0;
    if (state_q == ST_GRANT) begin
      out_valid_o         = valid_g;
      out_data_o          = beat_g.data;
      req_ready_o[gidx_q] = out_ready_i;
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = (state_q == ST_GRANT);

  assign xfer      = out_valid_o & out_ready_i;
  assign burst_inc = burst_q + BURST_W'(1);
  assign idle_inc  = idle_q + IDLE_W'(1);
  assign burst_hit = xfer & (burst_inc == BURST_W'(MAX_BURST));
  // A timeout needs valid low, so it never coincides with a transfer.
  assign idle_hit  = ~valid_g & (idle_inc == IDLE_W'(IDLE_TIMEOUT));
  assign rel       = (xfer & beat_g.last) | burst_hit | idle_hit;
  assign ptr_adv   = (gidx_q == LAST_IDX) ? '0 : gidx_q + IDX_W'(1);

  // Next-state, grant, pointer and counter update.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    burst_d = burst_q;
    idle_d  = idle_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_GRANT;
          grant_d = pick;
          gidx_d  = pick_idx;
          burst_d = '0;
          idle_d  = '0;
        end
      end
      ST_GRANT: begin
        if (xfer) begin
          burst_d = burst_inc;
        end
        idle_d = valid_g ? '0 : idle_inc;
        if (rel) begin
          state_d = ST_IDLE;
          grant_d = '0;
          ptr_d   = ptr_adv;
          burst_d = '0;
          idle_d  = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      burst_q <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      burst_q <= burst_d;
      idle_q  <= idle_d;
    end
  end

`ifndef SYNTHESIS
  a_grant_onehot : assert property (@(posedge clk_i) disable iff (!rstn_i)
    $onehot0(grant_q));
  a_busy_matches_grant : assert property (@(posedge clk_i) disable iff (!rstn_i)
    ((state_q == ST_GRANT) == (grant_q != '0)));
  a_ready_only_granted : assert property (@(posedge clk_i) disable iff (!rstn_i)
    ((req_ready_o & ~grant_q) == '0));
`endif

endmodule

// File: tb/tb_cdc_in_arbiter.sv
// Self-checking bench for cdc_in_arbiter: pick table plus scoreboarded packet sequences.
// DUT a uses MAX_BURST=64, DUT b uses MAX_BURST=4; both IDLE_TIMEOUT=16.
module tb_cdc_in_arbiter;

  logic        clk;
  logic        rstn;
  logic [31:0] req_data;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic        out_ready;

  logic [3:0]  a_ready, a_grant, b_ready, b_grant;
  logic [7:0]  a_data, b_data;
  logic        a_valid, a_busy, b_valid, b_busy;

  logic        sel_b;
  logic [3:0]  s_ready, s_grant;
  logic [7:0]  s_data;
  logic        s_valid, s_busy;

  int          n_vec;
  int          n_err;
  int          idle_cycles;
  int          n;

  logic [8:0]  src_mem [4][16];
  int          src_rd [4];
  int          src_wr [4];
  logic [3:0]  gate;
  logic [11:0] exp_q [$];

  typedef struct {
    logic [3:0] valid;
    logic       ordy;
    logic [3:0] exp_grant;
    logic [7:0] exp_data;
  } vec_t;
  vec_t vecs [7];

  cdc_in_arbiter #(.REQUESTERS(4), .MAX_BURST(64), .IDLE_TIMEOUT(16)) dut_a (
    .clk_i(clk), .rstn_i(rstn), .req_data_i(req_data), .req_valid_i(req_valid),
    .req_last_i(req_last), .req_ready_o(a_ready), .out_data_o(a_data),
    .out_valid_o(a_valid), .out_ready_i(out_ready), .grant_o(a_grant), .busy_o(a_busy));

  cdc_in_arbiter #(.REQUESTERS(4), .MAX_BURST(4), .IDLE_TIMEOUT(16)) dut_b (
    .clk_i(clk), .rstn_i(rstn), .req_data_i(req_data), .req_valid_i(req_valid),
    .req_last_i(req_last), .req_ready_o(b_ready), .out_data_o(b_data),
    .out_valid_o(b_valid), .out_ready_i(out_ready), .grant_o(b_grant), .busy_o(b_busy));

  assign s_ready = sel_b ? b_ready : a_ready;
  assign s_grant = sel_b ? b_grant : a_grant;
  assign s_data  = sel_b ? b_data  : a_data;
  assign s_valid = sel_b ? b_valid : a_valid;
  assign s_busy  = sel_b ? b_busy  : a_busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_src(input int r, input logic [7:0] d, input logic last);
    src_mem[r][src_wr[r]] = {last, d};
    src_wr[r]++;
  endtask

  task automatic exp_push(input int r, input logic [7:0] d);
    exp_q.push_back({4'(r), d});
  endtask

  task automatic drive();
    logic [8:0] b;
    for (int r = 0; r < 4; r++) begin
      if (src_rd[r] < src_wr[r] && !gate[r]) begin
        b = src_mem[r][src_rd[r]];
        req_valid[r]        = 1'b1;
        req_last[r]         = b[8];
        req_data[8*r +: 8]  = b[7:0];
      end else begin
        req_valid[r]        = 1'b0;
        req_last[r]         = 1'b0;
        req_data[8*r +: 8]  = 8'h00;
      end
    end
  endtask

  task automatic sample();
    logic [11:0] e;
    logic [3:0]  onehot;
    for (int r = 0; r < 4; r++) begin
      if (req_valid[r] && s_ready[r]) src_rd[r]++;
    end
    if (s_busy) begin
      check("ready_mirror", 32'(s_ready), 32'(s_grant & {4{out_ready}}));
      check("valid_follow", 32'(s_valid), 32'(|(req_valid & s_grant)));
    end else begin
      check("idle_quiet", 32'({s_valid, s_ready}), 32'd0);
      idle_cycles++;
    end
    if (s_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("xfer_expected", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        onehot = 4'b0001 << e[11:8];
        check("xfer_data", 32'(s_data), 32'(e[7:0]));
        check("xfer_grant", 32'(s_grant), 32'(onehot));
      end
    end
  endtask

  task automatic cycle();
    drive();
    #2;
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_empty(input int budget, output int cnt);
    cnt = 0;
    while (exp_q.size() > 0 && cnt < budget) begin
      cycle();
      cnt++;
    end
    check("drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic reset_all();
    rstn = 1'b0;
    for (int r = 0; r < 4; r++) begin
      src_rd[r] = 0;
      src_wr[r] = 0;
    end
    gate        = 4'h0;
    exp_q.delete();
    out_ready   = 1'b1;
    idle_cycles = 0;
    drive();
    @(posedge clk);
    #3;
    check("rst_a", 32'({a_grant, a_busy, a_valid, a_data, a_ready}), 32'd0);
    check("rst_b", 32'({b_grant, b_busy, b_valid, b_data, b_ready}), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rstn = 1'b0;
    sel_b = 1'b0;
    req_valid = '0;
    req_last = '0;
    req_data = '0;
    out_ready = 1'b1;

    // Pick from ptr=0 after reset: {valid, out_ready, expected grant, expected byte}.
    vecs[0] = '{4'b0001, 1'b1, 4'b0001, 8'hA0};
    vecs[1] = '{4'b0110, 1'b1, 4'b0010, 8'hA1};
    vecs[2] = '{4'b1000, 1'b1, 4'b1000, 8'hA3};
    vecs[3] = '{4'b1111, 1'b1, 4'b0001, 8'hA0};
    vecs[4] = '{4'b1100, 1'b1, 4'b0100, 8'hA2};
    vecs[5] = '{4'b1010, 1'b0, 4'b0010, 8'hA1};
    vecs[6] = '{4'b0000, 1'b1, 4'b0000, 8'h00};

    for (int i = 0; i < 7; i++) begin
      reset_all();
      req_valid = vecs[i].valid;
      req_data  = 32'hA3A2_A1A0;
      req_last  = 4'hF;
      out_ready = vecs[i].ordy;
      #2;
      check("tbl_idle_quiet", 32'({a_valid, a_ready}), 32'd0);
      @(posedge clk);
      #1;
      check("tbl_grant", 32'(a_grant), 32'(vecs[i].exp_grant));
      check("tbl_busy", 32'(a_busy), 32'(|vecs[i].exp_grant));
      check("tbl_out", 32'({a_valid, a_data}), 32'({|vecs[i].exp_grant, vecs[i].exp_data}));
      check("tbl_ready", 32'(a_ready), 32'(vecs[i].ordy ? vecs[i].exp_grant : 4'h0));
    end

    // Single requester, 5-byte packet, then ptr=1 decides r1 before r0.
    sel_b = 1'b0;
    reset_all();
    for (int k = 0; k < 5; k++) begin
      push_src(0, 8'(8'h10 + k), k == 4);
      exp_push(0, 8'(8'h10 + k));
    end
    cycle();
    check("single_grant", 32'(a_grant), 32'h1);
    run_until_empty(20, n);
    check("single_cycles", 32'(n), 32'd5);
    check("single_released", 32'({a_busy, a_grant}), 32'd0);
    push_src(0, 8'h15, 1'b1);
    push_src(1, 8'h16, 1'b1);
    exp_push(1, 8'h16);
    exp_push(0, 8'h15);
    run_until_empty(20, n);
    check("ptr_after_single", 32'(n), 32'd4);

    // Contention: four 2-byte packets, served 0,1,2,3 with one bubble each.
    reset_all();
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 2; k++) begin
        push_src(r, 8'(8'h20 + 2 * r + k), k == 1);
        exp_push(r, 8'(8'h20 + 2 * r + k));
      end
    end
    run_until_empty(40, n);
    check("contend_cycles", 32'(n), 32'd12);
    check("contend_bubbles", 32'(idle_cycles), 32'd4);

    // Burst cap of 4: r2 is split around r1's packet.
    sel_b = 1'b1;
    reset_all();
    for (int k = 0; k < 10; k++) push_src(2, 8'(8'h30 + k), k == 9);
    for (int k = 0; k < 4; k++) exp_push(2, 8'(8'h30 + k));
    exp_push(1, 8'h50);
    exp_push(1, 8'h51);
    for (int k = 4; k < 10; k++) exp_push(2, 8'(8'h30 + k));
    cycle();
    check("burst_grant", 32'(b_grant), 32'h4);
    push_src(1, 8'h50, 1'b0);
    push_src(1, 8'h51, 1'b1);
    run_until_empty(40, n);
    check("burst_cycles", 32'(n), 32'd15);
    check("burst_bubbles", 32'(idle_cycles), 32'd4);

    // Idle timeout: valid drops after byte 1, grant revoked on the 16th idle cycle.
    sel_b = 1'b0;
    reset_all();
    push_src(0, 8'h60, 1'b0);
    push_src(0, 8'h61, 1'b0);
    push_src(0, 8'h62, 1'b1);
    exp_push(0, 8'h60);
    cycle();
    cycle();
    check("to_first_byte", 32'(exp_q.size()), 32'd0);
    gate = 4'b0001;
    repeat (15) cycle();
    check("to_busy_15", 32'(a_busy), 32'd1);
    cycle();
    check("to_busy_16", 32'(a_busy), 32'd0);
    repeat (4) cycle();
    check("to_stays_idle", 32'({a_busy, a_grant}), 32'd0);
    gate = 4'b0000;
    exp_push(0, 8'h61);
    exp_push(0, 8'h62);
    run_until_empty(10, n);
    check("to_resume_cycles", 32'(n), 32'd3);

    // Backpressure 1,0,0,1,... with cap 4: stalls must not count toward the burst.
    sel_b = 1'b1;
    reset_all();
    for (int k = 0; k < 5; k++) begin
      push_src(3, 8'(8'h70 + k), k == 4);
      exp_push(3, 8'(8'h70 + k));
    end
    cycle();
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    cycle();
    cycle();
    out_ready = 1'b1;
    cycle();
    check("bp_hold_after_stall", 32'(b_busy), 32'd1);
    check("bp_src_consumed", 32'(src_rd[3]), 32'd2);
    run_until_empty(20, n);
    check("bp_cycles", 32'(n), 32'd4);

    // Reset in the middle of a packet, then ptr must be back at 0.
    sel_b = 1'b0;
    reset_all();
    push_src(1, 8'h40, 1'b1);
    exp_push(1, 8'h40);
    run_until_empty(5, n);
    for (int k = 0; k < 5; k++) push_src(0, 8'(8'h80 + k), k == 4);
    exp_push(0, 8'h80);
    exp_push(0, 8'h81);
    cycle();
    cycle();
    cycle();
    drive();
    #2;
    check("mid_byte3", 32'({a_valid, a_data}), 32'h182);
    rstn = 1'b0;
    #1;
    check("mid_rst_outputs", 32'({a_grant, a_busy, a_valid, a_data, a_ready}), 32'd0);
    reset_all();
    push_src(1, 8'h91, 1'b1);
    push_src(2, 8'h92, 1'b1);
    exp_push(1, 8'h91);
    exp_push(2, 8'h92);
    run_until_empty(10, n);
    check("mid_ptr_reset", 32'(n), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
